// File: rtl/lot_input_conditioner_if.sv
// rtl/lot_input_conditioner_if.sv - board-side button/switch bundle for the lottery input conditioner
//
// Purpose: carries the raw board inputs and the conditioned outputs between
//          the board side and lot_input_conditioner.
// Signals:
//   insere_raw, fim_raw, fim_jogo_raw : raw push-buttons, asynchronous to clk
//   num_raw [0:3]                     : raw slide switches
//   insere, fim, fim_jogo             : one-cycle pulses per accepted press
//   num [0:3]                         : number captured with the last insere pulse
// Modports: master = board/stimulus side, slave = conditioner side.
interface lot_input_conditioner_if;
  logic       insere_raw;
  logic       fim_raw;
  logic       fim_jogo_raw;
  logic [0:3] num_raw;
  logic       insere;
  logic       fim;
  logic       fim_jogo;
  logic [0:3] num;

  modport master (
    output insere_raw, fim_raw, fim_jogo_raw, num_raw,
    input  insere, fim, fim_jogo, num
  );

  modport slave (
    input  insere_raw, fim_raw, fim_jogo_raw, num_raw,
    output insere, fim, fim_jogo, num
  );
endinterface

// File: rtl/lot_input_conditioner.sv
// rtl/lot_input_conditioner.sv - synchronise, debounce and pulse-convert the lottery buttons
//
// Purpose: 2-flop synchronises the three raw buttons and the 4-bit switch
//          bank, debounces each button with its own FSM and counter, emits a
//          single-cycle pulse per accepted press and snapshots num with each
//          insere pulse.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : lot_input_conditioner_if.slave (raw inputs in, pulses and num out)
// Optional feature: define LOT_BTN_PRIORITY_EN to allow at most one pulse per
//   cycle with priority fim_jogo > fim > insere; losing presses are dropped.
module lot_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  lot_input_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_e;

  // Raw level that means "not pressed"; sync flops reset to it.
  localparam logic [2:0]       RAW_INACTIVE = {3{BTN_ACTIVE_LOW}};
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button index: 0 = insere, 1 = fim, 2 = fim_jogo.
  logic [2:0] raw;
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [2:0] btn_act;
  logic [0:3] num_sync1_q, num_sync1_d;
  logic [0:3] num_sync2_q, num_sync2_d;
  logic [0:3] num_q, num_d;
  logic [2:0] pulse_q, pulse_d;
  logic [2:0] hit;

  btn_state_e       state_q [3];
  btn_state_e       state_d [3];
  logic [CNT_W-1:0] cnt_q   [3];
  logic [CNT_W-1:0] cnt_d   [3];

  assign raw = {bus.fim_jogo_raw, bus.fim_raw, bus.insere_raw};

  // Polarity is normalised after the synchronisers so the FSMs only see active=1.
  assign btn_act = sync2_q ^ RAW_INACTIVE;

  always_comb begin
    sync1_d     = raw;
    sync2_d     = sync1_q;
    num_sync1_d = bus.num_raw;
    num_sync2_d = num_sync1_q;
  end

  // Per-button debounce FSMs; hit marks the edge a press is accepted.
  always_comb begin
    hit = 3'b000;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (btn_act[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_act[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] >= CNT_LAST) begin
            state_d[i] = PRESSED;
            hit[i]     = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_act[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_act[i]) begin
            state_d[i] = PRESSED;
          end else if (cnt_q[i] >= CNT_LAST) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output pulses and num snapshot; the FSMs advance regardless of which
  // pulse wins, so a dropped press is never replayed later.
  always_comb begin
`ifdef LOT_BTN_PRIORITY_EN
    if (hit[2]) begin
      pulse_d = 3'b100;
    end else if (hit[1]) begin
      pulse_d = 3'b010;
    end else if (hit[0]) begin
      pulse_d = 3'b001;
    end else begin
      pulse_d = 3'b000;
    end
`else
    pulse_d = hit;
`endif
    num_d = pulse_d[0] ? num_sync2_q : num_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= RAW_INACTIVE;
      sync2_q     <= RAW_INACTIVE;
      num_sync1_q <= '0;
      num_sync2_q <= '0;
      num_q       <= '0;
      pulse_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      num_sync1_q <= num_sync1_d;
      num_sync2_q <= num_sync2_d;
      num_q       <= num_d;
      pulse_q     <= pulse_d;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.insere   = pulse_q[0];
  assign bus.fim      = pulse_q[1];
  assign bus.fim_jogo = pulse_q[2];
  assign bus.num      = num_q;

endmodule

// File: tb/tb_lot_input_conditioner.sv
// tb/tb_lot_input_conditioner.sv - self-checking bench for lot_input_conditioner
module tb_lot_input_conditioner;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lot_input_conditioner_if ifc ();

  lot_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a button's accepted level flips once its synchronised
  // level has disagreed with it for D+1 consecutive samples; a flip to
  // pressed is a pulse. Synchronisers are modelled as a 2-sample delay.
  logic [2:0] m_h1 = '0, m_h2 = '0, m_acc = '0, m_pulse = '0;
  int         m_run [3] = '{0, 0, 0};
  logic [0:3] m_n1 = '0, m_n2 = '0, m_num = '0;
  int         cyc = 0;

  always @(posedge clk) begin
    logic [2:0] raw_act;
    logic [2:0] flip;
    cyc++;
    raw_act = ~{ifc.fim_jogo_raw, ifc.fim_raw, ifc.insere_raw};
    if (reset) begin
      m_h1 = '0; m_h2 = '0; m_acc = '0; m_pulse = '0;
      m_n1 = '0; m_n2 = '0; m_num = '0;
      for (int b = 0; b < 3; b++) m_run[b] = 0;
    end else begin
      flip = '0;
      for (int b = 0; b < 3; b++) begin
        if (m_h2[b] != m_acc[b]) begin
          m_run[b]++;
          if (m_run[b] == D + 1) begin
            m_acc[b] = m_h2[b];
            m_run[b] = 0;
            flip[b]  = m_acc[b];
          end
        end else begin
          m_run[b] = 0;
        end
      end
`ifdef LOT_BTN_PRIORITY_EN
      m_pulse = flip[2] ? 3'b100 : flip[1] ? 3'b010 : flip[0] ? 3'b001 : 3'b000;
`else
      m_pulse = flip;
`endif
      if (m_pulse[0]) m_num = m_n2;
      m_h2 = m_h1;
      m_h1 = raw_act;
      m_n2 = m_n1;
      m_n1 = ifc.num_raw;
    end
  end

  // Per-cycle comparison against the model, plus pulse bookkeeping.
  logic       chk_en = 1'b0;
  int         n_p [3]    = '{0, 0, 0};
  int         last_p [3] = '{0, 0, 0};
  logic [0:3] pulse_num  = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("insere", ifc.insere, m_pulse[0]);
      check_eq("fim", ifc.fim, m_pulse[1]);
      check_eq("fim_jogo", ifc.fim_jogo, m_pulse[2]);
      check_eq("num", ifc.num, m_num);
    end
    if (ifc.insere === 1'b1) begin n_p[0]++; last_p[0] = cyc; pulse_num = ifc.num; end
    if (ifc.fim === 1'b1) begin n_p[1]++; last_p[1] = cyc; end
    if (ifc.fim_jogo === 1'b1) begin n_p[2]++; last_p[2] = cyc; end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int         c0;
  int         n0 [3];
  int         hold [3];
  logic [2:0] lvl;

  initial begin
    reset            = 1'b1;
    ifc.insere_raw   = 1'b1;
    ifc.fim_raw      = 1'b1;
    ifc.fim_jogo_raw = 1'b1;
    ifc.num_raw      = 4'b1010;
    step(1);
    chk_en = 1'b1;
    check_eq("rst_num", ifc.num, 4'b0000);
    check_eq("rst_pulses", {ifc.fim_jogo, ifc.fim, ifc.insere}, 3'b000);
    step(2);
    reset = 1'b0;
    step(20);
    check_eq("post_rst_no_pulse", n_p[0] + n_p[1] + n_p[2], 0);

    // Clean press
    ifc.num_raw = 4'b0110;
    n0[0] = n_p[0]; c0 = cyc;
    ifc.insere_raw = 1'b0;
    step(30);
    check_eq("clean_count", n_p[0] - n0[0], 1);
    check_eq("clean_latency", last_p[0] - c0, 7);
    check_eq("clean_num", pulse_num, 4'b0110);
    ifc.insere_raw = 1'b1;
    step(12);

    // Press bounce, then release bounce
    n0[1] = n_p[1];
    for (int k = 0; k < 12; k++) begin
      ifc.fim_raw = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    check_eq("bounce_no_pulse", n_p[1] - n0[1], 0);
    c0 = cyc;
    ifc.fim_raw = 1'b0;
    step(20);
    check_eq("bounce_count", n_p[1] - n0[1], 1);
    check_eq("bounce_latency", last_p[1] - c0, 7);
    ifc.fim_raw = 1'b1; step(1);
    ifc.fim_raw = 1'b0; step(1);
    ifc.fim_raw = 1'b1; step(20);
    check_eq("release_bounce", n_p[1] - n0[1], 1);

    // Number hold
    ifc.num_raw = 4'b0011;
    ifc.insere_raw = 1'b0; step(15);
    ifc.insere_raw = 1'b1; step(15);
    check_eq("hold_first", ifc.num, 4'b0011);
    ifc.num_raw = 4'b1111;
    step(10);
    check_eq("hold_kept", ifc.num, 4'b0011);
    ifc.insere_raw = 1'b0; step(15);
    check_eq("hold_new", ifc.num, 4'b1111);
    ifc.insere_raw = 1'b1; step(15);

    // Reset mid-count
    n0[2] = n_p[2]; c0 = cyc;
    ifc.fim_jogo_raw = 1'b0;
    step(4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);
    check_eq("midrst_no_pulse", n_p[2] - n0[2], 0);
    step(10);
    check_eq("midrst_count", n_p[2] - n0[2], 1);
    check_eq("midrst_latency", last_p[2] - c0, 12);
    ifc.fim_jogo_raw = 1'b1;
    step(12);

    // Simultaneous insere + fim_jogo (num was cleared by the reset above)
    ifc.num_raw = 4'b0101;
    n0[0] = n_p[0]; n0[2] = n_p[2];
    ifc.insere_raw = 1'b0; ifc.fim_jogo_raw = 1'b0;
    step(12);
    check_eq("sim_fj_count", n_p[2] - n0[2], 1);
`ifdef LOT_BTN_PRIORITY_EN
    check_eq("sim_ins_dropped", n_p[0] - n0[0], 0);
    check_eq("sim_num_kept", ifc.num, 4'b0000);
`else
    check_eq("sim_ins_count", n_p[0] - n0[0], 1);
    check_eq("sim_same_cycle", last_p[0], last_p[2]);
    check_eq("sim_num", ifc.num, 4'b0101);
`endif
    ifc.insere_raw = 1'b1; ifc.fim_jogo_raw = 1'b1;
    step(12);

    // Randomised bouncing buttons, switches and occasional reset
    lvl = 3'b111;
    for (int b = 0; b < 3; b++) hold[b] = 1;
    for (int t = 0; t < 3000; t++) begin
      for (int b = 0; b < 3; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          lvl[b]  = ~lvl[b];
          hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 6);
        end
      end
      ifc.insere_raw   = lvl[0];
      ifc.fim_raw      = lvl[1];
      ifc.fim_jogo_raw = lvl[2];
      if ($urandom_range(0, 3) == 0) ifc.num_raw = 4'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      step(1);
    end
    reset = 1'b0;
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
